seq_div_40by8: RTL
==================

Name: seq_div_40by8

Overview:
- Iterative restoring divider. Inverse of the team's 32x8 array multiplier: takes a DIVIDEND_W-bit dividend (multiplier product width) and a DIVISOR_W-bit divisor.
- Returns quotient and remainder. Round-trip check: dividing a 32x8 product by its 8-bit operand recovers the 32-bit operand with remainder 0.
- Resolves one quotient bit per clock. Input side and output side each use a valid/ready handshake.

Parameters:
- DIVIDEND_W, 40, dividend and quotient width.
- DIVISOR_W, 8, divisor and remainder width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  block can accept an operation.
- dividend  input  DIVIDEND_W  numerator, unsigned.
- divisor  input  DIVISOR_W  denominator, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  DIVIDEND_W  dividend / divisor.
- remainder  output  DIVISOR_W  dividend mod divisor.
- div_by_zero  output  1  divisor was 0 for this result.

Behaviour:
- Reset is synchronous and active-high. When rst is sampled high: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- Reset mid-CALC or mid-DONE aborts the operation. The result is discarded and never presented.
- States are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - Acceptance happens on an edge where in_valid&&in_ready.
  - divisor!=0: latch divisor, load dividend into the quotient/shift register, clear the partial remainder (DIVISOR_W+1 bits), set counter=DIVIDEND_W-1, go to CALC.
  - divisor==0: quotient=all ones, remainder=0, div_by_zero=1, go straight to DONE. out_valid is high after that same edge (1-cycle latency).
- CALC:
  - in_ready=0.
  - Each edge: shift {rem,q} left one bit. If shifted rem >= divisor, then rem -= divisor and q[0]=1, else q[0]=0.
  - The counter decrements each edge. On the edge where counter==0, go to DONE.
  - The subtraction uses DIVISOR_W+1 bits, so there is no overflow at divisor=2^DIVISOR_W-1.
- Latency: acceptance at edge k gives out_valid high after edge k+DIVIDEND_W (40 cycles by default).
- DONE:
  - out_valid=1, in_ready=0.
  - quotient, remainder and div_by_zero hold stable while out_valid&&!out_ready (backpressure may last indefinitely).
  - On an edge with out_ready=1: out_valid=0, div_by_zero=0, go to IDLE. quotient and remainder keep their last values.
  - A new input is not accepted on the same edge as output handoff. in_ready rises the cycle after.
- Ignored inputs: in_valid and input data are ignored outside IDLE. out_ready is ignored outside DONE.
- Arithmetic: unsigned only. remainder < divisor always when div_by_zero=0. quotient*divisor+remainder==dividend.
- Edge cases:
  - dividend=0: quotient=0, remainder=0, full latency.
  - divisor=1: quotient=dividend, remainder=0.

Optional Feature:
- Macro: SEQ_DIV_Q32_OVF_EN.
- When defined:
  - Extra port q_ovf (output, 1 bit), asserted with out_valid when quotient[DIVIDEND_W-1:32]!=0. This flags a quotient not representable as a 32-bit multiplier operand.
  - q_ovf is also forced to 1 on div_by_zero.
  - q_ovf resets to 0, holds under backpressure, and clears on handoff.
- When undefined: port and logic are absent, all other behaviour is identical.

Test Plan:
- Basic: dividend=1000, divisor=7 → out_valid exactly 40 cycles after accept; quotient=142, remainder=6, div_by_zero=0.
- Max operands: dividend=40'hFF_FFFF_FFFF, divisor=8'hFF → quotient=40'h01_0101_0101, remainder=0. With SEQ_DIV_Q32_OVF_EN, q_ovf=1.
- Round-trip against the 32x8 multiplier:
  - A=32'hDEADBEEF, B=8'h5A; feed the bench-model product A*B with divisor B → quotient=32'hDEADBEEF zero-extended, remainder=0, q_ovf=0.
  - Repeat for 1000 random A/B with B!=0.
- Divide by zero: dividend=40'h12_3456_789A, divisor=0 → out_valid 1 cycle after accept; quotient=all ones, remainder=0, div_by_zero=1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → outputs stable, in_ready=0, a new in_valid is ignored. Raising out_ready → out_valid drops next edge, in_ready=1 the following cycle.
- Reset mid-operation: assert rst 10 cycles into CALC → next cycle in_ready=1, out_valid=0, all outputs 0. A subsequent 100/10 operation yields quotient=10, remainder=0.

Source files
------------

// File: rtl/seq_div_40by8.sv
// Iterative restoring divider: one quotient bit per clock, valid/ready on both sides.
// Optional SEQ_DIV_Q32_OVF_EN adds q_ovf, flagging quotients wider than 32 bits.
module seq_div_40by8 #(
    parameter int DIVIDEND_W = 40,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
`ifdef SEQ_DIV_Q32_OVF_EN
    output logic                  q_ovf,
`endif
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                state;
    logic [DIVIDEND_W-1:0] q_reg;
    logic [DIVISOR_W-1:0]  rem_reg;
    logic [DIVISOR_W-1:0]  dsr_reg;
    logic [CNT_W-1:0]      count;

    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W-1:0]  diff;
    logic                  fits;
    logic [DIVIDEND_W-1:0] q_step;
    logic [DIVISOR_W-1:0]  rem_step;

    // The partial remainder stays below the divisor, so only the shifted value
    // needs the extra bit; the compare is DIVISOR_W+1 wide and cannot overflow.
    always_comb begin
        shifted  = {rem_reg, q_reg[DIVIDEND_W-1]};
        fits     = (shifted >= {1'b0, dsr_reg});
        diff     = shifted[DIVISOR_W-1:0] - dsr_reg;
        q_step   = {q_reg[DIVIDEND_W-2:0], fits};
        rem_step = fits ? diff : shifted[DIVISOR_W-1:0];
    end

    assign quotient  = q_reg;
    assign remainder = rem_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            q_reg       <= '0;
            rem_reg     <= '0;
            dsr_reg     <= '0;
            count       <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIV_Q32_OVF_EN
            q_ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            q_reg       <= '1;
                            rem_reg     <= '0;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
`ifdef SEQ_DIV_Q32_OVF_EN
                            q_ovf       <= 1'b1;
`endif
                            state       <= DONE;
                        end else begin
                            dsr_reg <= divisor;
                            q_reg   <= dividend;
                            rem_reg <= '0;
                            count   <= LAST_CNT;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    q_reg   <= q_step;
                    rem_reg <= rem_step;
                    if (count == '0) begin
                        out_valid <= 1'b1;
`ifdef SEQ_DIV_Q32_OVF_EN
                        q_ovf     <= |q_step[DIVIDEND_W-1:32];
`endif
                        state     <= DONE;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Results stay put after handoff; only the flags clear.
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        div_by_zero <= 1'b0;
`ifdef SEQ_DIV_Q32_OVF_EN
                        q_ovf       <= 1'b0;
`endif
                        in_ready    <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
